// File: rtl/key_debounce_8.sv
// Eight independent key debouncers: two-flop synchroniser, per-channel
// mismatch counter, registered clean level plus one-cycle press/release strobes.
module key_debounce_8 #(
  parameter int CNT_WIDTH      = 20,
  parameter int DEBOUNCE_MAX   = 1000000,
  parameter bit RAW_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw_in,
  output logic [7:0] level,
  output logic [7:0] press,
  // "release" is a reserved word in SystemVerilog, hence "released".
  output logic [7:0] released,
  output logic       any_press
);

  // Count value on which a persistent mismatch is finally accepted.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_MAX - 1);

  logic [7:0]           polarised;
  logic [7:0]           sync1;
  logic [7:0]           sync2;
  logic [CNT_WIDTH-1:0] cnt [8];

  assign polarised = raw_in ^ {8{RAW_ACTIVE_LOW}};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      level    <= '0;
      press    <= '0;
      released <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= polarised;
      sync2 <= sync1;
      for (int i = 0; i < 8; i++) begin
        press[i]    <= 1'b0;
        released[i] <= 1'b0;
        // Any return to the current level discards the partial count.
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level[i]    <= sync2[i];
          cnt[i]      <= '0;
          press[i]    <= sync2[i];
          released[i] <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign any_press = |press;

endmodule

// File: tb/tb_key_debounce_8.sv
// Directed bench for key_debounce_8 with DEBOUNCE_MAX=4: one DUT per polarity.
module tb_key_debounce_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw_in;
  logic [7:0] level, press, released;
  logic       any_press;

  logic       rst_b;
  logic [7:0] raw_b;
  logic [7:0] level_b, press_b, released_b;
  logic       any_press_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  key_debounce_8 #(.CNT_WIDTH(3), .DEBOUNCE_MAX(4), .RAW_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .level(level), .press(press), .released(released), .any_press(any_press)
  );

  key_debounce_8 #(.CNT_WIDTH(3), .DEBOUNCE_MAX(4), .RAW_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst_b), .raw_in(raw_b),
    .level(level_b), .press(press_b), .released(released_b), .any_press(any_press_b)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    raw_in = 8'hFF;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (level !== 8'h00) $display("[TB] FAIL reset_level k=%0d got %h want 00", k, level); else passed++;
      total++; if (press !== 8'h00) $display("[TB] FAIL reset_press k=%0d got %h want 00", k, press); else passed++;
      total++; if (released !== 8'h00) $display("[TB] FAIL reset_release k=%0d got %h want 00", k, released); else passed++;
      total++; if (any_press !== 1'b0) $display("[TB] FAIL reset_any k=%0d got %b want 0", k, any_press); else passed++;
    end
    rst = 1'b0;
    raw_in = 8'h00;
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++; if (level !== 8'h00) $display("[TB] FAIL post_reset_level k=%0d got %h want 00", k, level); else passed++;
    end
  endtask

  // Raw 00 -> 01: sampled at E0, level flips at E5, visible after the 6th tick.
  task automatic test_clean_press();
    logic [7:0] el, ep;
    raw_in = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      tick();
      el = (k >= 6) ? 8'h01 : 8'h00;
      ep = (k == 6) ? 8'h01 : 8'h00;
      total++; if (level !== el) $display("[TB] FAIL press_level k=%0d got %h want %h", k, level, el); else passed++;
      total++; if (press !== ep) $display("[TB] FAIL press_strobe k=%0d got %h want %h", k, press, ep); else passed++;
      total++; if (released !== 8'h00) $display("[TB] FAIL press_release k=%0d got %h want 00", k, released); else passed++;
      total++; if (any_press !== (k == 6)) $display("[TB] FAIL press_any k=%0d got %b want %b", k, any_press, (k == 6)); else passed++;
    end
  endtask

  task automatic test_bounce();
    logic [7:0] el, ep;
    int npress = 0;
    for (int b = 0; b < 4; b++) begin
      raw_in = (b % 2 == 0) ? 8'h09 : 8'h01;
      for (int k = 1; k <= 2; k++) begin
        tick();
        if (press !== 8'h00) npress++;
        total++; if (level !== 8'h01) $display("[TB] FAIL bounce_hold b=%0d k=%0d got %h want 01", b, k, level); else passed++;
      end
    end
    raw_in = 8'h09;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (press !== 8'h00) npress++;
      el = (k >= 6) ? 8'h09 : 8'h01;
      ep = (k == 6) ? 8'h08 : 8'h00;
      total++; if (level !== el) $display("[TB] FAIL bounce_level k=%0d got %h want %h", k, level, el); else passed++;
      total++; if (press !== ep) $display("[TB] FAIL bounce_press k=%0d got %h want %h", k, press, ep); else passed++;
    end
    total++; if (npress != 1) $display("[TB] FAIL bounce_press_count got %0d want 1", npress); else passed++;
  endtask

  task automatic test_release_multi();
    logic [7:0] el, ep, er;
    // 09 -> 81: bit 7 presses and bit 3 releases on the same edge.
    raw_in = 8'h81;
    for (int k = 1; k <= 7; k++) begin
      tick();
      el = (k >= 6) ? 8'h81 : 8'h09;
      ep = (k == 6) ? 8'h80 : 8'h00;
      er = (k == 6) ? 8'h08 : 8'h00;
      total++; if (level !== el) $display("[TB] FAIL mixed_level k=%0d got %h want %h", k, level, el); else passed++;
      total++; if (press !== ep) $display("[TB] FAIL mixed_press k=%0d got %h want %h", k, press, ep); else passed++;
      total++; if (released !== er) $display("[TB] FAIL mixed_release k=%0d got %h want %h", k, released, er); else passed++;
    end
    raw_in = 8'h00;
    for (int k = 1; k <= 7; k++) begin
      tick();
      el = (k >= 6) ? 8'h00 : 8'h81;
      er = (k == 6) ? 8'h81 : 8'h00;
      total++; if (level !== el) $display("[TB] FAIL release_level k=%0d got %h want %h", k, level, el); else passed++;
      total++; if (press !== 8'h00) $display("[TB] FAIL release_press k=%0d got %h want 00", k, press); else passed++;
      total++; if (released !== er) $display("[TB] FAIL release_strobe k=%0d got %h want %h", k, released, er); else passed++;
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] el, ep;
    raw_in = 8'h10;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (level !== 8'h00) $display("[TB] FAIL midrst_pre k=%0d got %h want 00", k, level); else passed++;
    end
    rst = 1'b1;
    tick();
    total++; if (level !== 8'h00) $display("[TB] FAIL midrst_level got %h want 00", level); else passed++;
    total++; if (press !== 8'h00) $display("[TB] FAIL midrst_press got %h want 00", press); else passed++;
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      el = (k >= 6) ? 8'h10 : 8'h00;
      ep = (k == 6) ? 8'h10 : 8'h00;
      total++; if (level !== el) $display("[TB] FAIL midrst_after_level k=%0d got %h want %h", k, level, el); else passed++;
      total++; if (press !== ep) $display("[TB] FAIL midrst_after_press k=%0d got %h want %h", k, press, ep); else passed++;
      total++; if (released !== 8'h00) $display("[TB] FAIL midrst_after_release k=%0d got %h want 00", k, released); else passed++;
    end
  endtask

  task automatic test_active_low();
    logic [7:0] el, ep;
    rst_b = 1'b1;
    raw_b = 8'hFF;
    tick();
    tick();
    total++; if (level_b !== 8'h00) $display("[TB] FAIL al_reset_level got %h want 00", level_b); else passed++;
    rst_b = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++; if (level_b !== 8'h00) $display("[TB] FAIL al_idle_level k=%0d got %h want 00", k, level_b); else passed++;
    end
    raw_b = 8'hFE;
    for (int k = 1; k <= 7; k++) begin
      tick();
      el = (k >= 6) ? 8'h01 : 8'h00;
      ep = (k == 6) ? 8'h01 : 8'h00;
      total++; if (level_b !== el) $display("[TB] FAIL al_level k=%0d got %h want %h", k, level_b, el); else passed++;
      total++; if (press_b !== ep) $display("[TB] FAIL al_press k=%0d got %h want %h", k, press_b, ep); else passed++;
      total++; if (released_b !== 8'h00) $display("[TB] FAIL al_release k=%0d got %h want 00", k, released_b); else passed++;
      total++; if (any_press_b !== (k == 6)) $display("[TB] FAIL al_any k=%0d got %b want %b", k, any_press_b, (k == 6)); else passed++;
    end
  endtask

  initial begin
    rst    = 1'b1;
    raw_in = 8'hFF;
    rst_b  = 1'b1;
    raw_b  = 8'hFF;
    #1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_multi();
    test_mid_reset();
    test_active_low();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
